// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// This block shares the common data bus (CDB) between NUM_REQ functional-unit
// result ports. Each cycle it grants at most one eligible requester in
// round-robin order. The granted tag and data go into a one-entry broadcast
// register, which drives the CDB in the following cycle.
//
// The ROB supplies invalidated_n_i, which has a 0 for each entry squashed by a
// flush. A requester whose tag is squashed is acknowledged and its result is
// discarded. A broadcast whose entry is squashed while it sits in the register
// is suppressed.
//
// Handshake (requester side): a result transfers on any cycle with
// req_valid_i[i] & req_ready_o[i]. The requester must hold valid, tag and data
// stable until that cycle. req_ready_o is combinational from the current
// inputs and the round-robin pointer only, and never depends on itself.
// The CDB side has no back-pressure: a broadcast is consumed in its cycle.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   reset_n_i        asynchronous active-low reset
//   req_valid_i      [NUM_REQ]          per-requester result valid
//   req_tag_i        [NUM_REQ*TAG_W]    ROB tag of each result (requester i at i*TAG_W)
//   req_data_i       [NUM_REQ*DATA_W]   result value (requester i at i*DATA_W)
//   req_ready_o      [NUM_REQ]          per-requester accept (grant or squash-discard)
//   invalidated_n_i  [ROB_DEPTH]        0 = ROB entry squashed
//   cdb_valid_o                         CDB broadcast valid
//   cdb_tag_o        [TAG_W]            broadcast ROB tag
//   cdb_data_o       [DATA_W]           broadcast data
//   set_rob_valid_o  [ROB_DEPTH]        one-hot mark-computed strobe to the ROB
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_DEPTH = 8,
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [ROB_DEPTH-1:0]        invalidated_n_i,
    output logic                        cdb_valid_o,
    output logic [TAG_W-1:0]            cdb_tag_o,
    output logic [DATA_W-1:0]           cdb_data_o,
    output logic [ROB_DEPTH-1:0]        set_rob_valid_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Unpacked views of the flattened request buses.
    logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] live;      // requester's ROB entry not squashed
    logic [NUM_REQ-1:0] squash;
    logic [NUM_REQ-1:0] elig;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign tag_arr[g]  = req_tag_i[g*TAG_W +: TAG_W];
        assign data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
        assign live[g]     = invalidated_n_i[tag_arr[g]];
    end

    assign squash = req_valid_i & ~live;
    assign elig   = req_valid_i & live;

    // Round-robin state and the broadcast register.
    logic [PTR_W-1:0]  rr_ptr;
    logic              bcast_valid;
    logic [TAG_W-1:0]  bcast_tag;
    logic [DATA_W-1:0] bcast_data;

    // Grant selection: the first eligible index at or after rr_ptr. The
    // candidate index is kept one bit wider so that the wrap past
    // NUM_REQ-1 also works when NUM_REQ is not a power of two.
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_vec;
    logic [PTR_W:0]     cand_sum;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && elig[cand_sum[PTR_W-1:0]]) begin
                grant_found                    = 1'b1;
                grant_idx                      = cand_sum[PTR_W-1:0];
                grant_vec[cand_sum[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    // A squashed request is acknowledged so that its producer drops it. This
    // does not use the single grant slot. Nothing is accepted while the block
    // is held in reset.
    assign req_ready_o = reset_n_i ? (squash | grant_vec) : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr      <= '0;
            bcast_valid <= 1'b0;
            bcast_tag   <= '0;
            bcast_data  <= '0;
        end else begin
            // The register never stalls. The valid bit lives for exactly one
            // cycle per grant. Tag and data hold their last granted value
            // between grants.
            bcast_valid <= grant_found;
            if (grant_found) begin
                bcast_tag  <= tag_arr[grant_idx];
                bcast_data <= data_arr[grant_idx];
                rr_ptr     <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    // A flush that lands in the broadcast cycle kills the broadcast. Tag and
    // data stay visible regardless of validity.
    assign cdb_valid_o     = bcast_valid & invalidated_n_i[bcast_tag];
    assign cdb_tag_o       = bcast_tag;
    assign cdb_data_o      = bcast_data;
    assign set_rob_valid_o = cdb_valid_o ? (ROB_DEPTH'(1) << bcast_tag) : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RD = 8;
    localparam int TW = 3;

    // ---------------- clock / reset / DUT ----------------
    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [N-1:0]      req_valid_i;
    logic [TW-1:0]     r_tag  [N];
    logic [DW-1:0]     r_data [N];
    wire  [N*TW-1:0]   req_tag_i;
    wire  [N*DW-1:0]   req_data_i;
    logic [N-1:0]      req_ready_o;
    logic [RD-1:0]     invalidated_n_i;
    logic              cdb_valid_o;
    logic [TW-1:0]     cdb_tag_o;
    logic [DW-1:0]     cdb_data_o;
    logic [RD-1:0]     set_rob_valid_o;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_tag_i[g*TW +: TW]  = r_tag[g];
        assign req_data_i[g*DW +: DW] = r_data[g];
    end

    cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ROB_DEPTH(RD)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .req_valid_i     (req_valid_i),
        .req_tag_i       (req_tag_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .invalidated_n_i (invalidated_n_i),
        .cdb_valid_o     (cdb_valid_o),
        .cdb_tag_o       (cdb_tag_o),
        .cdb_data_o      (cdb_data_o),
        .set_rob_valid_o (set_rob_valid_o)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model / scoreboard ----------------
    // The model is built from the arbitration rules. A pointer integer picks
    // the first eligible requester at or after it, mod N. exp_q holds the
    // pending {tag,data} broadcasts in the order they were granted.
    logic [TW+DW-1:0] exp_q[$];
    int               m_rr;
    logic [TW-1:0]    m_last_tag;
    logic [DW-1:0]    m_last_data;

    logic [N-1:0]     exp_ready;
    logic             exp_gfound;
    int               exp_gidx;
    logic             exp_cv;
    logic [TW-1:0]    exp_ct;
    logic [DW-1:0]    exp_cd;
    logic [RD-1:0]    exp_set;

    task automatic model_reset();
        m_rr        = 0;
        m_last_tag  = '0;
        m_last_data = '0;
        exp_q.delete();
    endtask

    task automatic model_expect();
        int idx;
        logic [TW+DW-1:0] front;
        exp_ready  = '0;
        exp_gfound = 1'b0;
        exp_gidx   = 0;
        if (reset_n_i) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid_i[i] && !invalidated_n_i[r_tag[i]]) exp_ready[i] = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!exp_gfound && req_valid_i[idx] && invalidated_n_i[r_tag[idx]]) begin
                    exp_gfound     = 1'b1;
                    exp_gidx       = idx;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
        exp_ct = m_last_tag;
        exp_cd = m_last_data;
        exp_cv = 1'b0;
        if (exp_q.size() != 0) begin
            front  = exp_q[0];
            exp_cv = invalidated_n_i[front[TW+DW-1:DW]];
        end
        exp_set = '0;
        if (exp_cv) exp_set[exp_ct] = 1'b1;
    endtask

    // Called at each rising edge, before the inputs change.
    task automatic model_advance();
        if (reset_n_i) begin
            model_expect();
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_gfound) begin
                exp_q.push_back({r_tag[exp_gidx], r_data[exp_gidx]});
                m_last_tag  = r_tag[exp_gidx];
                m_last_data = r_data[exp_gidx];
                m_rr        = (exp_gidx + 1) % N;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i     = '0;
        invalidated_n_i = '1;
        for (int i = 0; i < N; i++) begin
            r_tag[i]  = '0;
            r_data[i] = '0;
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n_i = 1'b0;
        model_reset();
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n_i = 1'b0;
        model_reset();
        req_valid_i     = 4'b1111;
        invalidated_n_i = 8'hFE;  // requester 0 (tag 0) squashed
        for (int i = 0; i < N; i++) begin
            r_tag[i]  = TW'(i);
            r_data[i] = $urandom;
        end
        #3;
        vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready_o); end
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_cdb_valid: got %b expected 0", cdb_valid_o); end
        vectors++; if (cdb_tag_o !== 3'd0) begin miscompares++; $display("FAIL reset_cdb_tag: got %0d expected 0", cdb_tag_o); end
        vectors++; if (cdb_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_cdb_data: got %h expected 0", cdb_data_o); end
        vectors++; if (set_rob_valid_o !== 8'h00) begin miscompares++; $display("FAIL reset_set_rob: got %h expected 00", set_rob_valid_o); end
        tick();
        clear_inputs();
        reset_n_i = 1'b1;
        tick();
        #3;
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_release_idle: got %b expected 0", cdb_valid_o); end
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid_i = 4'b0001;
        r_tag[0]    = 3'd5;
        r_data[0]   = 32'hDEADBEEF;
        #3;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b expected 0001", req_ready_o); end
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_c0_valid: got %b expected 0", cdb_valid_o); end
        tick();
        req_valid_i = '0;
        #3;
        vectors++; if (cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", cdb_valid_o); end
        vectors++; if (cdb_tag_o !== 3'd5) begin miscompares++; $display("FAIL single_tag: got %0d expected 5", cdb_tag_o); end
        vectors++; if (cdb_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data: got %h expected deadbeef", cdb_data_o); end
        vectors++; if (set_rob_valid_o !== 8'h20) begin miscompares++; $display("FAIL single_set_rob: got %h expected 20", set_rob_valid_o); end
        tick();
        #3;
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle: got %b expected 0", cdb_valid_o); end
        #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  e_ready;
        logic [DW-1:0] prev_data;
        apply_reset();
        req_valid_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            r_tag[i]  = TW'(i);
            r_data[i] = $urandom;
        end
        prev_data = '0;
        for (int k = 0; k < 6; k++) begin
            #3;
            e_ready = 4'b0001 << (k % N);
            vectors++; if (req_ready_o !== e_ready) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready_o, e_ready); end
            if (k >= 1) begin
                vectors++; if (cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL rr_bcast_valid[%0d]: got %b expected 1", k, cdb_valid_o); end
                vectors++; if (cdb_tag_o !== TW'((k - 1) % N)) begin miscompares++; $display("FAIL rr_bcast_tag[%0d]: got %0d expected %0d", k, cdb_tag_o, (k - 1) % N); end
                vectors++; if (cdb_data_o !== prev_data) begin miscompares++; $display("FAIL rr_bcast_data[%0d]: got %h expected %h", k, cdb_data_o, prev_data); end
            end
            prev_data = r_data[k % N];
            tick();
            r_data[(k - 1 + N) % N] = $urandom;  // accepted last cycle: new result, same tag
        end
        clear_inputs();
    endtask

    task automatic test_squash_req();
        apply_reset();
        req_valid_i     = 4'b1010;
        r_tag[1]        = 3'd2;
        r_tag[3]        = 3'd4;
        r_data[1]       = 32'h1111_2222;
        r_data[3]       = 32'h3333_4444;
        invalidated_n_i = 8'hFB;
        #3;
        vectors++; if (req_ready_o !== 4'b1010) begin miscompares++; $display("FAIL squash_req_ready: got %b expected 1010", req_ready_o); end
        tick();
        req_valid_i     = '0;
        invalidated_n_i = '1;
        #3;
        vectors++; if (cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL squash_req_valid: got %b expected 1", cdb_valid_o); end
        vectors++; if (cdb_tag_o !== 3'd4) begin miscompares++; $display("FAIL squash_req_tag: got %0d expected 4", cdb_tag_o); end
        vectors++; if (set_rob_valid_o !== 8'h10) begin miscompares++; $display("FAIL squash_req_set_rob: got %h expected 10", set_rob_valid_o); end
        tick();
        #3;
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL squash_req_no_second: got %b expected 0", cdb_valid_o); end
        #1;
    endtask

    task automatic test_squash_flight();
        logic [DW-1:0] d;
        apply_reset();
        d           = $urandom;
        req_valid_i = 4'b0001;
        r_tag[0]    = 3'd6;
        r_data[0]   = d;
        #3;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL flight_ready: got %b expected 0001", req_ready_o); end
        tick();
        req_valid_i     = '0;
        invalidated_n_i = 8'hBF;
        #3;
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL flight_valid: got %b expected 0", cdb_valid_o); end
        vectors++; if (set_rob_valid_o !== 8'h00) begin miscompares++; $display("FAIL flight_set_rob: got %h expected 00", set_rob_valid_o); end
        vectors++; if (cdb_tag_o !== 3'd6) begin miscompares++; $display("FAIL flight_tag_visible: got %0d expected 6", cdb_tag_o); end
        vectors++; if (cdb_data_o !== d) begin miscompares++; $display("FAIL flight_data_visible: got %h expected %h", cdb_data_o, d); end
        tick();
        invalidated_n_i = '1;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_valid_i = 4'b0010;
        r_tag[1]    = 3'd3;
        r_data[1]   = 32'hCAFE_F00D;
        tick();
        req_valid_i = '0;
        #3;
        vectors++; if (cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL areset_pre_valid: got %b expected 1", cdb_valid_o); end
        // Assert reset between edges during the broadcast cycle.
        reset_n_i = 1'b0;
        model_reset();
        req_valid_i = 4'b0101;
        r_tag[0]    = 3'd1;
        r_tag[2]    = 3'd2;
        r_data[0]   = 32'hA0A0_0000;
        r_data[2]   = 32'hA2A2_0000;
        #1;
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL areset_valid_drop: got %b expected 0", cdb_valid_o); end
        vectors++; if (set_rob_valid_o !== 8'h00) begin miscompares++; $display("FAIL areset_set_rob: got %h expected 00", set_rob_valid_o); end
        vectors++; if (cdb_tag_o !== 3'd0) begin miscompares++; $display("FAIL areset_tag: got %0d expected 0", cdb_tag_o); end
        vectors++; if (cdb_data_o !== 32'd0) begin miscompares++; $display("FAIL areset_data: got %h expected 0", cdb_data_o); end
        vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL areset_ready: got %b expected 0000", req_ready_o); end
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        #1;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL areset_first_grant: got %b expected 0001", req_ready_o); end
        vectors++; if (cdb_valid_o !== 1'b0) begin miscompares++; $display("FAIL areset_no_pulse: got %b expected 0", cdb_valid_o); end
        tick();
        req_valid_i[0] = 1'b0;
        #3;
        vectors++; if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL areset_second_grant: got %b expected 0100", req_ready_o); end
        vectors++; if (cdb_tag_o !== 3'd1 || cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL areset_bcast0: got v=%b t=%0d expected v=1 t=1", cdb_valid_o, cdb_tag_o); end
        tick();
        req_valid_i = '0;
        #3;
        vectors++; if (cdb_tag_o !== 3'd2 || cdb_valid_o !== 1'b1) begin miscompares++; $display("FAIL areset_bcast2: got v=%b t=%0d expected v=1 t=2", cdb_valid_o, cdb_tag_o); end
        tick();
    endtask

    task automatic test_fairness();
        int wait_cnt [N];
        int grants   [N];
        apply_reset();
        req_valid_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            r_tag[i]    = TW'(i);
            r_data[i]   = $urandom;
            wait_cnt[i] = 0;
            grants[i]   = 0;
        end
        for (int c = 0; c < 24; c++) begin
            #3;
            for (int i = 0; i < N; i++) begin
                wait_cnt[i]++;
                if (req_ready_o[i]) begin
                    vectors++;
                    if (wait_cnt[i] > N) begin miscompares++; $display("FAIL fair_wait[%0d]: got %0d cycles expected <= %0d", i, wait_cnt[i], N); end
                    wait_cnt[i] = 0;
                    grants[i]++;
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            vectors++; if (grants[i] != 6) begin miscompares++; $display("FAIL fair_grant_count[%0d]: got %0d expected 6", i, grants[i]); end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        acc = '1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_i[i] || acc[i]) begin
                    req_valid_i[i] = ($urandom_range(0, 3) != 0);
                    r_tag[i]       = TW'($urandom_range(0, RD - 1));
                    r_data[i]      = $urandom;
                end
            end
            for (int b = 0; b < RD; b++) invalidated_n_i[b] = ($urandom_range(0, 7) != 0);
            #3;
            model_expect();
            vectors++; if (req_ready_o !== exp_ready) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready_o, exp_ready); end
            vectors++; if (cdb_valid_o !== exp_cv) begin miscompares++; $display("FAIL rand_cdb_valid[%0d]: got %b expected %b", c, cdb_valid_o, exp_cv); end
            vectors++; if (cdb_tag_o !== exp_ct) begin miscompares++; $display("FAIL rand_cdb_tag[%0d]: got %0d expected %0d", c, cdb_tag_o, exp_ct); end
            vectors++; if (cdb_data_o !== exp_cd) begin miscompares++; $display("FAIL rand_cdb_data[%0d]: got %h expected %h", c, cdb_data_o, exp_cd); end
            vectors++; if (set_rob_valid_o !== exp_set) begin miscompares++; $display("FAIL rand_set_rob[%0d]: got %h expected %h", c, set_rob_valid_o, exp_set); end
            acc = exp_ready;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        reset_n_i = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_squash_req();
        test_squash_flight();
        test_async_reset();
        test_fairness();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters sharing the common data bus (CDB).
REQ-002 Parameter DATA_W, default 32, result data width.
REQ-003 Parameter ROB_DEPTH, default 8, ROB entries; tag width TAG_W = log2(ROB_DEPTH) = 3.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 req_valid_i  input  NUM_REQ  per-requester result valid.
REQ-007 req_tag_i  input  NUM_REQ x TAG_W  ROB entry of each result.
REQ-008 req_data_i  input  NUM_REQ x DATA_W  result value.
REQ-009 req_ready_o  output  NUM_REQ  per-requester accept; transfer when valid & ready.
REQ-010 invalidated_n_i  input  ROB_DEPTH  from ROB; 0 = entry squashed by flush.
REQ-011 cdb_valid_o  output  1  CDB broadcast valid.
REQ-012 cdb_tag_o  output  TAG_W  broadcast ROB tag.
REQ-013 cdb_data_o  output  DATA_W  broadcast data.
REQ-014 set_rob_valid_o  output  ROB_DEPTH  one-hot mark-computed strobe to ROB.

Function
REQ-015 Requester i is squashed when req_valid_i[i] & ~invalidated_n_i[req_tag_i[i]]; a squashed request SHALL get req_ready_o[i]=1 that cycle, be discarded, and never broadcast.
REQ-016 Requester i is eligible when req_valid_i[i] & invalidated_n_i[req_tag_i[i]].
REQ-017 Each cycle at most one eligible requester SHALL be granted (req_ready_o=1), chosen round-robin: first eligible index at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-018 Non-granted, non-squashed requesters SHALL see req_ready_o=0 and must hold valid/tag/data stable until accepted.
REQ-019 req_ready_o SHALL be combinational from current inputs and rr_ptr; no dependence on req_ready_o feedback.
REQ-020 On a grant to index w, rr_ptr SHALL update to (w+1) mod NUM_REQ next edge; with no grant rr_ptr holds.
REQ-021 Granted tag/data SHALL be captured into a one-entry broadcast register; broadcast appears exactly 1 cycle after the grant cycle and lasts exactly 1 cycle.
REQ-022 Broadcast register valid bit SHALL load 1 on a grant, else 0; register never stalls (CDB always consumed).
REQ-023 cdb_valid_o = bcast_valid & invalidated_n_i[bcast_tag]; a broadcast whose entry is squashed in its broadcast cycle SHALL be suppressed.
REQ-024 cdb_tag_o/cdb_data_o SHALL show register contents regardless of validity.
REQ-025 set_rob_valid_o SHALL be one-hot at cdb_tag_o when cdb_valid_o=1, else all zero.
REQ-026 Throughput: one broadcast per cycle sustained; any continuously eligible requester SHALL be granted within NUM_REQ cycles.
REQ-027 Squash and grant in the same cycle to different requesters SHALL both occur; squash does not consume the grant slot.
REQ-028 Tag width arithmetic wraps mod ROB_DEPTH; rr_ptr arithmetic wraps mod NUM_REQ (non-power-of-2 NUM_REQ supported).

Reset
REQ-029 reset_n_i low SHALL asynchronously clear rr_ptr=0, bcast_valid=0, bcast_tag=0, bcast_data=0; hence cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0, set_rob_valid_o=0.
REQ-030 During reset req_ready_o SHALL be 0 for all requesters, including squashed ones.
REQ-031 Reset asserted mid-broadcast SHALL drop the pending broadcast; no set_rob_valid_o pulse after reset release without a new grant.
REQ-032 First grant after reset release SHALL favour requester 0.

Verification
REQ-033 Single request: reset, req_valid_i=0001, tag 5, data 0xDEADBEEF -> ready[0]=1 cycle 0; cycle 1 cdb_valid_o=1, tag 5, data 0xDEADBEEF, set_rob_valid_o=0x20.
REQ-034 Round-robin: all 4 requesters valid continuously (tags 0..3) -> grants 0,1,2,3,0 on consecutive cycles; broadcasts one cycle later, one per cycle.
REQ-035 Squash on request: req 1 valid tag 2, invalidated_n_i[2]=0, req 3 valid tag 4 -> ready=1010 same cycle; only tag 4 broadcast next cycle.
REQ-036 Squash in flight: grant tag 6 cycle 0, invalidated_n_i[6]=0 in cycle 1 -> cdb_valid_o=0, set_rob_valid_o=0 in cycle 1.
REQ-037 Async reset: assert reset_n_i between edges during a broadcast cycle -> cdb_valid_o drops immediately; after release with req 2 and req 0 valid, req 0 granted first.
REQ-038 Fairness: req 0 held valid while reqs 1-3 continuously valid -> req 0 never waits more than 4 cycles between grants.
